divider_fx_iter: RTL and testbench

//  Parametrised iterative fixed-point divider: a/b -> WIDTH integer + FRAC_BITS fraction quotient bits, one bit per clk.

---
 rtl/divider_fx_iter_pkg.sv | 18 +
 rtl/divider_fx_iter_step.sv | 25 ++
 rtl/divider_fx_iter.sv | 163 ++++++++++++++++
 tb/tb_divider_fx_iter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/divider_fx_iter_pkg.sv
// Shared types and helpers for the iterative fixed-point divider.
package div_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    // Width of a down-counter that must hold the value qw itself.
    function automatic int cnt_w(input int qw);
        if (qw < 2) begin
            return 1;
        end
        return $clog2(qw + 1);
    endfunction

endpackage

// File: rtl/divider_fx_iter_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_step #(
    parameter int WIDTH = 24
) (
    input  logic [WIDTH:0]   p,
    input  logic             din,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   p_next,
    output logic             q_bit
);

    logic [WIDTH+1:0] t;
    logic [WIDTH:0]   diff;

    // Trial subtraction. When t >= b the true difference is below b, so
    // computing it modulo 2^(WIDTH+1) loses nothing.
    always_comb begin
        t      = {p, din};
        q_bit  = (t >= {2'b00, b});
        diff   = t[WIDTH:0] - {1'b0, b};
        p_next = q_bit ? diff : t[WIDTH:0];
    end

endmodule

// File: rtl/divider_fx_iter.sv
// Iterative fixed-point divider: a/b -> WIDTH integer + FRAC_BITS fraction
// quotient bits, one bit per clock, with valid/ready handshake on both sides.
module divider_fx_iter
    import div_pkg::*;
#(
    parameter  int WIDTH     = 24,
    parameter  int FRAC_BITS = 24,
    localparam int QW        = WIDTH + FRAC_BITS,
    localparam int FW        = (FRAC_BITS > 0) ? FRAC_BITS : 1
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic [FW-1:0]    f,
    output logic [WIDTH-1:0] rem,
    output logic             sticky,
    output logic             div_by_zero
);

    localparam int CNT_W = cnt_w(QW);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;   // dividend, consumed MSB first
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH:0]   p_q, p_d;         // partial remainder
    logic [QW-1:0]    quot_q, quot_d;   // quotient shift register
    logic [QW-1:0]    res_quot_q, res_quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             sticky_q, sticky_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   step_p;
    logic             step_bit;
    logic [QW-1:0]    quot_step;
    logic             accept;

    div_step #(.WIDTH(WIDTH)) u_step (
        .p      (p_q),
        .din    (a_sh_q[WIDTH-1]),
        .b      (b_q),
        .p_next (step_p),
        .q_bit  (step_bit)
    );

    // Handshake: ready when idle, or when the held result is being retired.
    always_comb begin
        in_ready  = (state_q == DIV_IDLE) || ((state_q == DIV_DONE) && out_ready);
        out_valid = (state_q == DIV_DONE);
        accept    = in_valid && in_ready && !flush;
        quot_step = QW'({quot_q, step_bit});
    end

    // Next-state logic: FSM, datapath and result registers.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_sh_d     = a_sh_q;
        b_d        = b_q;
        p_d        = p_q;
        quot_d     = quot_q;
        res_quot_d = res_quot_q;
        rem_d      = rem_q;
        sticky_d   = sticky_q;
        dbz_d      = dbz_q;

        case (state_q)
            DIV_CALC: begin
                // Once the dividend is exhausted, zeros shift in for the fraction.
                a_sh_d = WIDTH'({a_sh_q, 1'b0});
                p_d    = step_p;
                quot_d = quot_step;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d    = DIV_DONE;
                    res_quot_d = quot_step;
                    rem_d      = step_p[WIDTH-1:0];
                    sticky_d   = |step_p;
                    dbz_d      = 1'b0;
                end
            end
            DIV_DONE: begin
                if (out_ready && !in_valid) begin
                    state_d = DIV_IDLE;
                end
            end
            default: ;
        endcase

        // A new operation may start from IDLE or while retiring a result.
        if (accept) begin
            a_sh_d = a;
            b_d    = b;
            p_d    = '0;
            quot_d = '0;
            if (b == '0) begin
                state_d    = DIV_DONE;
                res_quot_d = {QW{1'b1}} << FRAC_BITS;
                rem_d      = '0;
                sticky_d   = 1'b0;
                dbz_d      = 1'b1;
            end else begin
                state_d = DIV_CALC;
                cnt_d   = CNT_W'(QW);
            end
        end

        // Abort overrides everything; the in-flight operation is dropped.
        if (flush) begin
            state_d = DIV_IDLE;
        end
    end

    // State and result registers with asynchronous reset.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q    <= DIV_IDLE;
            cnt_q      <= '0;
            a_sh_q     <= '0;
            b_q        <= '0;
            p_q        <= '0;
            quot_q     <= '0;
            res_quot_q <= '0;
            rem_q      <= '0;
            sticky_q   <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_sh_q     <= a_sh_d;
            b_q        <= b_d;
            p_q        <= p_d;
            quot_q     <= quot_d;
            res_quot_q <= res_quot_d;
            rem_q      <= rem_d;
            sticky_q   <= sticky_d;
            dbz_q      <= dbz_d;
        end
    end

    // Split the registered quotient into integer and fraction fields.
    generate
        if (FRAC_BITS > 0) begin : g_frac
            assign q = res_quot_q[QW-1:FRAC_BITS];
            assign f = res_quot_q[FRAC_BITS-1:0];
        end else begin : g_int
            assign q = res_quot_q;
            assign f = '0;
        end
    endgenerate

    assign rem         = rem_q;
    assign sticky      = sticky_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider_fx_iter.sv
// Directed bench for divider_fx_iter at WIDTH=8, FRAC_BITS=8.
module tb_divider_fx_iter;

    logic       clk = 1'b0;
    logic       arst;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] q;
    logic [7:0] f;
    logic [7:0] rem;
    logic       sticky;
    logic       div_by_zero;

    int total = 0;
    int bad   = 0;

    divider_fx_iter #(.WIDTH(8), .FRAC_BITS(8)) dut (
        .clk         (clk),
        .arst        (arst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .q           (q),
        .f           (f),
        .rem         (rem),
        .sticky      (sticky),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present operands for one cycle from IDLE; returns at the negedge after the accept edge.
    task automatic issue(input logic [7:0] av, input logic [7:0] bv);
        @(negedge clk);
        chk("in_ready_before_issue", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        @(negedge clk);
        in_valid = 1'b0;
        a        = ~av;   // operands must already be latched
        b        = ~bv;
    endtask

    // Latency counts clock edges from the accept edge (inclusive) to out_valid.
    task automatic wait_valid(input string tag, input int exp_lat);
        int lat;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic check_res(input string tag, input logic [7:0] eq, input logic [7:0] ef,
                             input logic [7:0] erem, input logic est, input logic edbz);
        chk({tag, "_q"}, 32'(q), 32'(eq));
        chk({tag, "_f"}, 32'(f), 32'(ef));
        chk({tag, "_rem"}, 32'(rem), 32'(erem));
        chk({tag, "_sticky"}, 32'(sticky), 32'(est));
        chk({tag, "_dbz"}, 32'(div_by_zero), 32'(edbz));
        $display("txn %s: q=%02h f=%02h rem=%02h sticky=%0b dbz=%0b", tag, q, f, rem, sticky, div_by_zero);
    endtask

    task automatic retire(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_retired"}, 32'(out_valid), 32'd0);
    endtask

    task automatic run(input string tag, input logic [7:0] av, input logic [7:0] bv,
                       input logic [7:0] eq, input logic [7:0] ef, input logic [7:0] erem,
                       input logic est, input logic edbz, input int elat);
        issue(av, bv);
        wait_valid(tag, elat);
        check_res(tag, eq, ef, erem, est, edbz);
        retire(tag);
    endtask

    initial begin
        logic [15:0] num;
        logic [15:0] eqf;
        logic [15:0] erm;
        logic [7:0]  ra;
        logic [7:0]  rb;
        logic        seen;

        arst      = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;

        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_q", 32'(q), 32'd0);
        chk("reset_f", 32'(f), 32'd0);
        chk("reset_rem", 32'(rem), 32'd0);
        chk("reset_sticky", 32'(sticky), 32'd0);
        chk("reset_dbz", 32'(div_by_zero), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(negedge clk);
        arst = 1'b0;

        // Directed quotients (hand-computed: Q = a*256/b, rem = a*256 mod b).
        run("d7_2",     8'd7,   8'd2,   8'h03, 8'h80, 8'h00, 1'b0, 1'b0, 17);
        run("d1_3",     8'd1,   8'd3,   8'h00, 8'h55, 8'h01, 1'b1, 1'b0, 17);
        run("dff_1",    8'hFF,  8'd1,   8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 17);
        run("dff_ff",   8'hFF,  8'hFF,  8'h01, 8'h00, 8'h00, 1'b0, 1'b0, 17);
        run("d5_0",     8'd5,   8'd0,   8'hFF, 8'h00, 8'h00, 1'b0, 1'b1, 1);
        run("d200_7",   8'd200, 8'd7,   8'h1C, 8'h92, 8'h02, 1'b1, 1'b0, 17);
        run("d0_5",     8'd0,   8'd5,   8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 17);

        // Back-to-back: retire of 100/10 coincides with accept of 7/2.
        @(negedge clk);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        a         = 8'd100;
        b         = 8'd10;
        @(negedge clk);
        a = 8'd7;
        b = 8'd2;
        wait_valid("b2b_first", 17);
        check_res("b2b_first", 8'h0A, 8'h00, 8'h00, 1'b0, 1'b0);
        chk("b2b_in_ready_at_done", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_no_bubble_state", 32'(out_valid), 32'd0);
        chk("b2b_busy", 32'(in_ready), 32'd0);
        wait_valid("b2b_second", 17);
        check_res("b2b_second", 8'h03, 8'h80, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        out_ready = 1'b0;
        chk("b2b_idle_after", 32'(out_valid), 32'd0);

        // Backpressure: result held, new operands ignored.
        issue(8'd1, 8'd3);
        wait_valid("bp", 17);
        in_valid = 1'b1;
        a        = 8'd9;
        b        = 8'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_hold", {8'(q), 8'(f), 8'(rem), 7'd0, sticky}, {8'h00, 8'h55, 8'h01, 8'h01});
        end
        in_valid = 1'b0;
        check_res("bp", 8'h00, 8'h55, 8'h01, 1'b1, 1'b0);
        retire("bp");

        // Flush mid-calculation: no result ever appears.
        issue(8'd7, 8'd2);
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        chk("flush_never_valid", 32'(seen), 32'd0);
        $display("txn flush: operation dropped");

        // Leave a non-zero result visible, then reset in the middle of a calculation.
        run("pre_arst", 8'd1, 8'd3, 8'h00, 8'h55, 8'h01, 1'b1, 1'b0, 17);
        issue(8'd200, 8'd7);
        repeat (5) @(negedge clk);
        #2 arst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_outputs", {8'(q), 8'(f), 8'(rem), 6'd0, sticky, div_by_zero}, 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        arst = 1'b0;
        $display("txn arst: mid-calculation reset");

        // Randomised operands vs. integer reference.
        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = (i % 7 == 3) ? 8'd0 : 8'($urandom_range(1, 255));
            num = {ra, 8'h00};
            if (rb == 8'd0) begin
                eqf = 16'hFF00;
                erm = 16'h0000;
            end else begin
                eqf = num / {8'h00, rb};
                erm = num % {8'h00, rb};
            end
            run("rand", ra, rb, eqf[15:8], eqf[7:0], erm[7:0], (erm != 16'h0000),
                (rb == 8'd0), (rb == 8'd0) ? 1 : 17);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
